// File: rtl/rv32_pkg.sv
// Shared RV32 constants and the write-back request bundle used by the register-file
// write-back controller and its arbiter.
package rv32_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;
   localparam int XLEN       = 32;

   localparam int WB_REQ_LSU = 0;
   localparam int WB_REQ_ALU = 1;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] addr;
      logic [XLEN-1:0]       data;
   } wb_req_t;

endpackage

// File: rtl/wb_arbiter.sv
// Two-way write-back arbiter with a one-hot grant, indexed by WB_REQ_LSU / WB_REQ_ALU.
// WB_RR_ARB_EN selects round-robin; otherwise the LSU has fixed priority over the ALU.
module wb_arbiter (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);
   import rv32_pkg::*;

`ifdef WB_RR_ARB_EN
   logic r_prio_alu;
   logic w_contended;

   assign w_contended = &req_i;

   // Only a contended grant moves the pointer; lone requesters leave it alone.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_prio_alu <= 1'b0;
      end else if (w_contended) begin
         r_prio_alu <= ~r_prio_alu;
      end
   end

   always_comb begin
      gnt_o = 2'b00;
      if (w_contended) begin
         if (r_prio_alu) gnt_o[WB_REQ_ALU] = 1'b1;
         else            gnt_o[WB_REQ_LSU] = 1'b1;
      end else begin
         gnt_o = req_i;
      end
   end
`else
   logic w_unused;

   assign w_unused = clk_i ^ rst_i;

   always_comb begin
      gnt_o = 2'b00;
      if (req_i[WB_REQ_LSU])      gnt_o[WB_REQ_LSU] = 1'b1;
      else if (req_i[WB_REQ_ALU]) gnt_o[WB_REQ_ALU] = 1'b1;
   end
`endif

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-back controller: busy-bit scoreboard with RAW/WAW issue stall, and
// ALU/LSU arbitration onto the single registered RF write port (WB_RR_ARB_EN selects round-robin).
module regfile_wb_ctrl #(
   parameter int NUM_REGS = rv32_pkg::NUM_REGS,
   parameter int XLEN     = rv32_pkg::XLEN
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            iss_valid_i,
   input  logic [rv32_pkg::REG_ADDR_W-1:0] iss_rs1_i,
   input  logic [rv32_pkg::REG_ADDR_W-1:0] iss_rs2_i,
   input  logic                            iss_rs1_use_i,
   input  logic                            iss_rs2_use_i,
   input  logic [rv32_pkg::REG_ADDR_W-1:0] iss_rd_i,
   input  logic                            iss_rd_wr_i,
   output logic                            iss_stall_o,
   input  logic                            alu_wb_valid_i,
   input  logic [rv32_pkg::REG_ADDR_W-1:0] alu_wb_addr_i,
   input  logic [XLEN-1:0]                 alu_wb_data_i,
   output logic                            alu_wb_ready_o,
   input  logic                            lsu_wb_valid_i,
   input  logic [rv32_pkg::REG_ADDR_W-1:0] lsu_wb_addr_i,
   input  logic [XLEN-1:0]                 lsu_wb_data_i,
   output logic                            lsu_wb_ready_o,
   output logic                            rf_wen_o,
   output logic [rv32_pkg::REG_ADDR_W-1:0] rf_waddr_o,
   output logic [XLEN-1:0]                 rf_wdata_o,
   output logic [NUM_REGS-1:0]             busy_o
);
   import rv32_pkg::*;

   wb_req_t [1:0]         w_req;
   wb_req_t               w_win;
   logic [1:0]            w_gnt;
   logic                  w_any_gnt;
   logic                  w_fire;
   logic [NUM_REGS-1:0]   w_busy_nxt;
   logic [NUM_REGS-1:0]   r_busy;
   logic                  r_wen;
   logic [REG_ADDR_W-1:0] r_waddr;
   logic [XLEN-1:0]       r_wdata;

   assign w_req[WB_REQ_LSU] = '{valid: lsu_wb_valid_i, addr: lsu_wb_addr_i, data: lsu_wb_data_i};
   assign w_req[WB_REQ_ALU] = '{valid: alu_wb_valid_i, addr: alu_wb_addr_i, data: alu_wb_data_i};

   wb_arbiter u_arb (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .req_i ({w_req[WB_REQ_ALU].valid, w_req[WB_REQ_LSU].valid}),
      .gnt_o (w_gnt)
   );

   assign alu_wb_ready_o = w_gnt[WB_REQ_ALU];
   assign lsu_wb_ready_o = w_gnt[WB_REQ_LSU];
   assign w_any_gnt      = |w_gnt;
   assign w_win          = w_gnt[WB_REQ_ALU] ? w_req[WB_REQ_ALU] : w_req[WB_REQ_LSU];

   assign iss_stall_o = iss_valid_i & ((iss_rs1_use_i & r_busy[iss_rs1_i]) |
                                       (iss_rs2_use_i & r_busy[iss_rs2_i]) |
                                       (iss_rd_wr_i   & r_busy[iss_rd_i]));
   assign w_fire      = iss_valid_i & ~iss_stall_o;

   // Clear from the landing write first, then set from issue, so a new writer wins a collision.
   always_comb begin
      w_busy_nxt = r_busy;
      if (r_wen) begin
         w_busy_nxt[r_waddr] = 1'b0;
      end
      if (w_fire && iss_rd_wr_i && (iss_rd_i != '0)) begin
         w_busy_nxt[iss_rd_i] = 1'b1;
      end
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busy_nxt;
      end
   end

   // An accepted x0 write is consumed here without ever raising the RF write enable.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wen   <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
      end else begin
         r_wen <= w_any_gnt && (w_win.addr != '0);
         if (w_any_gnt) begin
            r_waddr <= w_win.addr;
            r_wdata <= w_win.data;
         end
      end
   end

   assign rf_wen_o   = r_wen;
   assign rf_waddr_o = r_waddr;
   assign rf_wdata_o = r_wdata;
   assign busy_o     = r_busy;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Bench for regfile_wb_ctrl: per-cycle reference model plus directed scenarios with
// literal expectations; honours WB_RR_ARB_EN when it is defined for the build.
module tb_regfile_wb_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        iss_valid, iss_rs1_use, iss_rs2_use, iss_rd_wr;
   logic [4:0]  iss_rs1, iss_rs2, iss_rd;
   logic        iss_stall;
   logic        alu_v, alu_rdy, lsu_v, lsu_rdy;
   logic [4:0]  alu_addr, lsu_addr;
   logic [31:0] alu_data, lsu_data;
   logic        rf_wen;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [31:0] busy;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   regfile_wb_ctrl dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .iss_valid_i    (iss_valid),
      .iss_rs1_i      (iss_rs1),
      .iss_rs2_i      (iss_rs2),
      .iss_rs1_use_i  (iss_rs1_use),
      .iss_rs2_use_i  (iss_rs2_use),
      .iss_rd_i       (iss_rd),
      .iss_rd_wr_i    (iss_rd_wr),
      .iss_stall_o    (iss_stall),
      .alu_wb_valid_i (alu_v),
      .alu_wb_addr_i  (alu_addr),
      .alu_wb_data_i  (alu_data),
      .alu_wb_ready_o (alu_rdy),
      .lsu_wb_valid_i (lsu_v),
      .lsu_wb_addr_i  (lsu_addr),
      .lsu_wb_data_i  (lsu_data),
      .lsu_wb_ready_o (lsu_rdy),
      .rf_wen_o       (rf_wen),
      .rf_waddr_o     (rf_waddr),
      .rf_wdata_o     (rf_wdata),
      .busy_o         (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a set of pending writers plus the single write waiting on the RF port.
   bit          m_init = 0;
   bit          m_busy [32];
   bit          m_wen;
   int          m_waddr;
   logic [31:0] m_wdata;
   bit          m_alu_turn;

   always @(negedge clk) begin
      bit          e_stall, e_alu, e_lsu;
      logic [31:0] e_busy;
      if (m_init) begin
         e_stall = iss_valid && ((iss_rs1_use && m_busy[iss_rs1]) ||
                                 (iss_rs2_use && m_busy[iss_rs2]) ||
                                 (iss_rd_wr   && m_busy[iss_rd]));
         e_lsu = 0;
         e_alu = 0;
         if (alu_v && lsu_v) begin
`ifdef WB_RR_ARB_EN
            if (m_alu_turn) e_alu = 1; else e_lsu = 1;
`else
            e_lsu = 1;
`endif
         end else begin
            e_alu = alu_v;
            e_lsu = lsu_v;
         end
         for (int i = 0; i < 32; i++) e_busy[i] = m_busy[i];
         chk("model_stall", iss_stall, e_stall);
         chk("model_alu_ready", alu_rdy, e_alu);
         chk("model_lsu_ready", lsu_rdy, e_lsu);
         chk("model_rf_wen", rf_wen, m_wen);
         chk("model_busy", busy, e_busy);
         if (m_wen) begin
            chk("model_rf_waddr", rf_waddr, m_waddr);
            chk("model_rf_wdata", rf_wdata, m_wdata);
         end
         // Advance the model to the state after the coming edge.
         if (!rst) begin
            if (m_wen) m_busy[m_waddr] = 0;
            if (iss_valid && !e_stall && iss_rd_wr && iss_rd != 0) m_busy[iss_rd] = 1;
            m_wen = 0;
            if (e_alu) begin
               m_wen = (alu_addr != 0); m_waddr = alu_addr; m_wdata = alu_data;
            end else if (e_lsu) begin
               m_wen = (lsu_addr != 0); m_waddr = lsu_addr; m_wdata = lsu_data;
            end
            if (alu_v && lsu_v) m_alu_turn = !m_alu_turn;
         end
      end
      if (rst) begin
         m_init = 1;
         foreach (m_busy[i]) m_busy[i] = 0;
         m_wen = 0;
         m_alu_turn = 0;
      end
   end

   task automatic idle();
      iss_valid = 0; iss_rs1_use = 0; iss_rs2_use = 0; iss_rd_wr = 0;
      iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0;
      alu_v = 0; alu_addr = 0; alu_data = 0;
      lsu_v = 0; lsu_addr = 0; lsu_data = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [4:0] rd, input logic wr,
                        input logic [4:0] rs1, input logic use1);
      iss_valid = 1; iss_rd = rd; iss_rd_wr = wr; iss_rs1 = rs1; iss_rs1_use = use1;
   endtask

   initial begin
      logic [4:0] exp_addr;
      idle();
      rst = 1;
      step(); step();
      rst = 0;

      // Reset with a write pending on the RF port and a busy register.
      issue(5'd6, 1, 5'd0, 0);
      alu_v = 1; alu_addr = 5'd2; alu_data = 32'h11;
      @(negedge clk);
      chk("lone_alu_ready", alu_rdy, 1);
      chk("first_issue_stall", iss_stall, 0);
      step();
      idle(); rst = 1;
      @(negedge clk);
      chk("pending_wen", rf_wen, 1);
      chk("busy6_before_rst", busy[6], 1);
      step();
      rst = 0;
      @(negedge clk);
      chk("rst_wen", rf_wen, 0);
      chk("rst_busy", busy, 0);
      chk("rst_waddr", rf_waddr, 0);
      chk("rst_wdata", rf_wdata, 0);

      // RAW on x5: grant in N, RF write in N+1, stall gone in N+2.
      step();
      issue(5'd5, 1, 5'd0, 0);
      @(negedge clk);
      chk("raw_producer_stall", iss_stall, 0);
      step();
      issue(5'd0, 0, 5'd5, 1);
      @(negedge clk);
      chk("raw_stall", iss_stall, 1);
      step();
      alu_v = 1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
      @(negedge clk);
      chk("raw_stall_grant", iss_stall, 1);
      chk("raw_alu_ready", alu_rdy, 1);
      step();
      alu_v = 0;
      @(negedge clk);
      chk("raw_wen", rf_wen, 1);
      chk("raw_waddr", rf_waddr, 5);
      chk("raw_wdata", rf_wdata, 32'hDEADBEEF);
      chk("raw_stall_wb", iss_stall, 1);
      step();
      @(negedge clk);
      chk("raw_stall_drop", iss_stall, 0);
      step();
      idle();

      // Contention: ALU to x3, LSU to x4, both valid for four cycles.
      alu_v = 1; alu_addr = 5'd3; alu_data = 32'hAAAA0003;
      lsu_v = 1; lsu_addr = 5'd4; lsu_data = 32'hBBBB0004;
      exp_addr = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
`ifdef WB_RR_ARB_EN
         chk("cont_lsu_ready", lsu_rdy, (i % 2 == 0));
         chk("cont_alu_ready", alu_rdy, (i % 2 == 1));
`else
         chk("cont_lsu_ready", lsu_rdy, 1);
         chk("cont_alu_ready", alu_rdy, 0);
`endif
         if (i > 0) chk("cont_waddr", rf_waddr, exp_addr);
         exp_addr = lsu_rdy ? 5'd4 : 5'd3;
         step();
      end
      idle();
      @(negedge clk);
`ifdef WB_RR_ARB_EN
      chk("cont_last_waddr", rf_waddr, 3);
`else
      chk("cont_last_waddr", rf_waddr, 4);
`endif
      chk("cont_last_wen", rf_wen, 1);

      // x0: never busy, write-back accepted but not written.
      step();
      issue(5'd0, 1, 5'd0, 0);
      lsu_v = 1; lsu_addr = 5'd0; lsu_data = 32'h123;
      @(negedge clk);
      chk("x0_lsu_ready", lsu_rdy, 1);
      step();
      idle();
      @(negedge clk);
      chk("x0_wen", rf_wen, 0);
      chk("x0_busy", busy[0], 0);

      // Clear of x7 coincides with a new issue writing x7: busy stays set.
      step();
      alu_v = 1; alu_addr = 5'd7; alu_data = 32'h77;
      @(negedge clk);
      chk("col_busy7_pre", busy[7], 0);
      step();
      idle();
      issue(5'd7, 1, 5'd0, 0);
      @(negedge clk);
      chk("col_wen", rf_wen, 1);
      chk("col_waddr", rf_waddr, 7);
      chk("col_stall", iss_stall, 0);
      step();
      idle();
      @(negedge clk);
      chk("col_busy7", busy[7], 1);

      // WAW on x9.
      step();
      issue(5'd9, 1, 5'd0, 0);
      step();
      @(negedge clk);
      chk("waw_stall", iss_stall, 1);
      step();
      alu_v = 1; alu_addr = 5'd9; alu_data = 32'h99;
      @(negedge clk);
      chk("waw_stall_grant", iss_stall, 1);
      step();
      alu_v = 0;
      @(negedge clk);
      chk("waw_stall_wb", iss_stall, 1);
      chk("waw_waddr", rf_waddr, 9);
      step();
      @(negedge clk);
      chk("waw_stall_drop", iss_stall, 0);
      step();
      idle();
      @(negedge clk);
      chk("waw_busy9", busy[9], 1);

      step(); step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
